// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU controller: FSM states, opcode/funct
// values and datapath mux selects.
package cpu_ctrl_pkg;

  localparam logic [5:0] RESET_ST  = 6'd0;
  localparam logic [5:0] FETCH0    = 6'd1;
  localparam logic [5:0] FETCH1    = 6'd2;
  localparam logic [5:0] FETCH2    = 6'd3;
  localparam logic [5:0] DECODE    = 6'd4;
  localparam logic [5:0] ADD_EX    = 6'd5;
  localparam logic [5:0] SUB_EX    = 6'd6;
  localparam logic [5:0] AND_EX    = 6'd7;
  localparam logic [5:0] ADDI_EX   = 6'd8;
  localparam logic [5:0] SLTI_EX   = 6'd9;
  localparam logic [5:0] SLL_EX    = 6'd10;
  localparam logic [5:0] SRL_EX    = 6'd11;
  localparam logic [5:0] R_WB      = 6'd12;
  localparam logic [5:0] I_WB      = 6'd13;
  localparam logic [5:0] SH_WB     = 6'd14;
  localparam logic [5:0] LUI_WB    = 6'd15;
  localparam logic [5:0] MFHI_WB   = 6'd16;
  localparam logic [5:0] MFLO_WB   = 6'd17;
  localparam logic [5:0] JR_ST     = 6'd18;
  localparam logic [5:0] BEQ_ST    = 6'd19;
  localparam logic [5:0] BNE_ST    = 6'd20;
  localparam logic [5:0] J_ST      = 6'd21;
  localparam logic [5:0] JAL_ST    = 6'd22;
  localparam logic [5:0] MEM_ADDR  = 6'd23;
  localparam logic [5:0] LW_RD     = 6'd24;
  localparam logic [5:0] LW_WAIT   = 6'd25;
  localparam logic [5:0] LW_WB     = 6'd26;
  localparam logic [5:0] SW_RD     = 6'd27;
  localparam logic [5:0] SW_WR     = 6'd28;
  localparam logic [5:0] MULT_ST   = 6'd29;
  localparam logic [5:0] MULT_WAIT = 6'd30;
  localparam logic [5:0] MULT_WR   = 6'd31;
  localparam logic [5:0] DIV_ST    = 6'd32;
  localparam logic [5:0] DIV_WAIT  = 6'd33;
  localparam logic [5:0] DIV_WR    = 6'd34;
  localparam logic [5:0] EXC_EPC   = 6'd35;
  localparam logic [5:0] EXC_RD    = 6'd36;
  localparam logic [5:0] EXC_WAIT  = 6'd37;
  localparam logic [5:0] EXC_PC    = 6'd38;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;

  localparam logic [1:0] IORD_ALUOUT = 2'd2;
  localparam logic [1:0] IORD_EXCPT  = 2'd3;
  localparam logic [1:0] ASA_A       = 2'd1;
  localparam logic [1:0] ASB_FOUR    = 2'd1;
  localparam logic [1:0] ASB_SE16    = 2'd2;
  localparam logic [1:0] ASB_BRANCH  = 2'd3;
  localparam logic [1:0] RDST_RD     = 2'd1;
  localparam logic [1:0] RDST_RA     = 2'd3;
  localparam logic [1:0] LS_BYTE     = 2'd2;

  localparam logic [1:0] EXC_OPCODE   = 2'd0;
  localparam logic [1:0] EXC_OVERFLOW = 2'd1;
  localparam logic [1:0] EXC_DIV0     = 2'd2;

  localparam logic [2:0] PCSRC_ALURES = 3'd0;
  localparam logic [2:0] PCSRC_ALUOUT = 3'd1;
  localparam logic [2:0] PCSRC_JUMP   = 3'd2;
  localparam logic [2:0] PCSRC_LS     = 3'd3;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_CMP = 3'b111;

  localparam logic [2:0] SHC_SLL = 3'd2;
  localparam logic [2:0] SHC_SRL = 3'd3;

  localparam logic [3:0] DS_ALUOUT = 4'd0;
  localparam logic [3:0] DS_LS     = 4'd1;
  localparam logic [3:0] DS_HI     = 4'd2;
  localparam logic [3:0] DS_LO     = 4'd3;
  localparam logic [3:0] DS_PC     = 4'd4;  // link value for jal
  localparam logic [3:0] DS_SL16   = 4'd6;
  localparam logic [3:0] DS_SHIFT  = 4'd8;

  // First post-decode state for an instruction; EXC_EPC marks an unsupported encoding.
  function automatic logic [5:0] dispatch(input logic [5:0] op, input logic [5:0] fn);
    logic [5:0] nxt;
    nxt = EXC_EPC;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD:  nxt = ADD_EX;
          FN_SUB:  nxt = SUB_EX;
          FN_AND:  nxt = AND_EX;
          FN_SLL:  nxt = SLL_EX;
          FN_SRL:  nxt = SRL_EX;
          FN_MFHI: nxt = MFHI_WB;
          FN_MFLO: nxt = MFLO_WB;
          FN_JR:   nxt = JR_ST;
          FN_MULT: nxt = MULT_ST;
          FN_DIV:  nxt = DIV_ST;
          default: nxt = EXC_EPC;
        endcase
      end
      OP_ADDI: nxt = ADDI_EX;
      OP_SLTI: nxt = SLTI_EX;
      OP_LUI:  nxt = LUI_WB;
      OP_BEQ:  nxt = BEQ_ST;
      OP_BNE:  nxt = BNE_ST;
      OP_J:    nxt = J_ST;
      OP_JAL:  nxt = JAL_ST;
      OP_LW:   nxt = MEM_ADDR;
      OP_SW:   nxt = MEM_ADDR;
      default: nxt = EXC_EPC;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/md_wait_counter.sv
// Down-counter timing the iterative multiply/divide unit: after a load, done is
// high on the MD_CYCLES-th following cycle. MD_CYCLES must be at least 1.
module md_wait_counter #(
  parameter int unsigned MD_CYCLES = 33
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam int unsigned CntW = (MD_CYCLES > 1) ? $clog2(MD_CYCLES + 1) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CntW'(MD_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == CntW'(1));

endmodule

// File: rtl/control_unit.sv
// Multi-cycle CPU control FSM: Moore outputs decoded from the state register
// (branch PCCtrl also follows eqf), with exception and mult/div sequencing.
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MD_CYCLES = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opCode,
  input  logic [5:0] funct,
  input  logic       eqf,
  input  logic       gtf,
  input  logic       ov,
  input  logic       div0,
  output logic       MemCtrl,
  output logic       PCCtrl,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ALUOutCtrl,
  output logic       EPCCtrl,
  output logic       HILOWrite,
  output logic       start,
  output logic       MDCtrl,
  output logic       SECtrl,
  output logic       ShiftSrc,
  output logic       ShiftAmt,
  output logic [1:0] IorD,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] RegDst,
  output logic [1:0] LSCtrl,
  output logic [1:0] SSCtrl,
  output logic [1:0] ExcptCtrl,
  output logic [2:0] ShiftCtrl,
  output logic [2:0] PCSrc,
  output logic [2:0] ALUCtrl,
  output logic [3:0] DataSrc
);

  logic [5:0] state_q, state_d;
  logic [1:0] exc_q, exc_d;
  logic       md_load, md_done;
  logic       unused_gtf;

  assign unused_gtf = gtf;
  assign md_load    = (state_q == MULT_ST) || (state_q == DIV_ST);

  md_wait_counter #(
    .MD_CYCLES(MD_CYCLES)
  ) u_md_wait (
    .clk  (clk),
    .reset(reset),
    .load (md_load),
    .done (md_done)
  );

  always_comb begin
    state_d = state_q;
    exc_d   = exc_q;
    case (state_q)
      RESET_ST: state_d = FETCH0;
      FETCH0:   state_d = FETCH1;
      FETCH1:   state_d = FETCH2;
      FETCH2:   state_d = DECODE;
      DECODE: begin
        state_d = dispatch(opCode, funct);
        if (state_d == EXC_EPC) exc_d = EXC_OPCODE;
      end
      ADD_EX, SUB_EX, ADDI_EX: begin
        if (ov) begin
          state_d = EXC_EPC;
          exc_d   = EXC_OVERFLOW;
        end else begin
          state_d = (state_q == ADDI_EX) ? I_WB : R_WB;
        end
      end
      AND_EX:    state_d = R_WB;
      SLTI_EX:   state_d = I_WB;
      SLL_EX,
      SRL_EX:    state_d = SH_WB;
      MEM_ADDR:  state_d = (opCode == OP_SW) ? SW_RD : LW_RD;
      LW_RD:     state_d = LW_WAIT;
      LW_WAIT:   state_d = LW_WB;
      SW_RD:     state_d = SW_WR;
      MULT_ST:   state_d = MULT_WAIT;
      MULT_WAIT: if (md_done) state_d = MULT_WR;
      DIV_ST:    state_d = DIV_WAIT;
      DIV_WAIT: begin
        if (md_done) begin
          if (div0) begin
            state_d = EXC_EPC;
            exc_d   = EXC_DIV0;
          end else begin
            state_d = DIV_WR;
          end
        end
      end
      EXC_EPC:   state_d = EXC_RD;
      EXC_RD:    state_d = EXC_WAIT;
      EXC_WAIT:  state_d = EXC_PC;
      // Every last-cycle state (and any illegal encoding) returns to fetch.
      default:   state_d = FETCH0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RESET_ST;
      exc_q   <= EXC_OPCODE;
    end else begin
      state_q <= state_d;
      exc_q   <= exc_d;
    end
  end

  always_comb begin
    MemCtrl    = 1'b0;
    PCCtrl     = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ALUOutCtrl = 1'b0;
    EPCCtrl    = 1'b0;
    HILOWrite  = 1'b0;
    start      = 1'b0;
    MDCtrl     = 1'b0;
    SECtrl     = 1'b0;
    ShiftSrc   = 1'b0;
    ShiftAmt   = 1'b0;
    IorD       = 2'd0;
    ALUSrcA    = 2'd0;
    ALUSrcB    = 2'd0;
    RegDst     = 2'd0;
    LSCtrl     = 2'd0;
    SSCtrl     = 2'd0;
    ExcptCtrl  = 2'd0;
    ShiftCtrl  = 3'd0;
    PCSrc      = 3'd0;
    ALUCtrl    = 3'd0;
    DataSrc    = 4'd0;
    case (state_q)
      FETCH2: begin
        IRWrite = 1'b1;
        ALUSrcB = ASB_FOUR;
        ALUCtrl = ALU_ADD;
        PCSrc   = PCSRC_ALURES;
        PCCtrl  = 1'b1;
      end
      DECODE: begin
        ALUSrcB    = ASB_BRANCH;
        ALUCtrl    = ALU_ADD;
        ALUOutCtrl = 1'b1;
      end
      ADD_EX, SUB_EX, AND_EX: begin
        ALUSrcA    = ASA_A;
        ALUOutCtrl = 1'b1;
        ALUCtrl    = (state_q == ADD_EX) ? ALU_ADD : (state_q == SUB_EX) ? ALU_SUB : ALU_AND;
      end
      ADDI_EX, SLTI_EX: begin
        ALUSrcA    = ASA_A;
        ALUSrcB    = ASB_SE16;
        ALUOutCtrl = 1'b1;
        ALUCtrl    = (state_q == ADDI_EX) ? ALU_ADD : ALU_CMP;
      end
      SLL_EX, SRL_EX: begin
        ShiftSrc  = 1'b1;
        ShiftAmt  = 1'b1;
        ShiftCtrl = (state_q == SLL_EX) ? SHC_SLL : SHC_SRL;
      end
      R_WB: begin
        RegWrite = 1'b1;
        RegDst   = RDST_RD;
        DataSrc  = DS_ALUOUT;
      end
      I_WB:    RegWrite = 1'b1;
      SH_WB: begin
        RegWrite = 1'b1;
        RegDst   = RDST_RD;
        DataSrc  = DS_SHIFT;
      end
      LUI_WB: begin
        RegWrite = 1'b1;
        DataSrc  = DS_SL16;
      end
      MFHI_WB, MFLO_WB: begin
        RegWrite = 1'b1;
        RegDst   = RDST_RD;
        DataSrc  = (state_q == MFHI_WB) ? DS_HI : DS_LO;
      end
      JR_ST: begin
        ALUSrcA = ASA_A;
        ALUCtrl = ALU_ADD;
        PCSrc   = PCSRC_ALURES;
        PCCtrl  = 1'b1;
      end
      BEQ_ST, BNE_ST: begin
        ALUSrcA = ASA_A;
        ALUCtrl = ALU_CMP;
        PCSrc   = PCSRC_ALUOUT;
        PCCtrl  = (state_q == BEQ_ST) ? eqf : !eqf;
      end
      J_ST: begin
        PCSrc  = PCSRC_JUMP;
        PCCtrl = 1'b1;
      end
      JAL_ST: begin
        PCSrc    = PCSRC_JUMP;
        PCCtrl   = 1'b1;
        RegWrite = 1'b1;
        RegDst   = RDST_RA;
        DataSrc  = DS_PC;
      end
      MEM_ADDR: begin
        ALUSrcA    = ASA_A;
        ALUSrcB    = ASB_SE16;
        ALUCtrl    = ALU_ADD;
        ALUOutCtrl = 1'b1;
      end
      LW_RD, SW_RD: IorD = IORD_ALUOUT;
      LW_WB: begin
        RegWrite = 1'b1;
        DataSrc  = DS_LS;
      end
      SW_WR: begin
        IorD    = IORD_ALUOUT;
        MemCtrl = 1'b1;
      end
      MULT_ST:   start = 1'b1;
      MULT_WR:   HILOWrite = 1'b1;
      DIV_ST: begin
        MDCtrl = 1'b1;
        start  = 1'b1;
      end
      DIV_WAIT:  MDCtrl = 1'b1;
      DIV_WR: begin
        MDCtrl    = 1'b1;
        HILOWrite = 1'b1;
      end
      EXC_EPC: begin
        ALUSrcB = ASB_FOUR;
        ALUCtrl = ALU_SUB;
        EPCCtrl = 1'b1;
      end
      EXC_RD: begin
        IorD      = IORD_EXCPT;
        ExcptCtrl = exc_q;
      end
      EXC_PC: begin
        LSCtrl = LS_BYTE;
        PCSrc  = PCSRC_LS;
        PCCtrl = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: an instruction-level model lists the expected
// control word per cycle; one process compares the DUT against it every cycle.
module tb_control_unit;

  localparam int MD = 33;

  typedef struct packed {
    logic memc, pcc, irw, rw, aoc, epcc, hilo, start;
    logic mdc, sec, shs, sha;
    logic [1:0] iord, asa, asb, rdst, ls, ss, exc;
    logic [2:0] shc, pcs, aluc;
    logic [3:0] ds;
  } ctl_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] opCode = '0, funct = '0;
  logic eqf = 1'b0, gtf = 1'b0, ov = 1'b0, div0 = 1'b0;
  logic MemCtrl, PCCtrl, IRWrite, RegWrite, ALUOutCtrl, EPCCtrl, HILOWrite, start;
  logic MDCtrl, SECtrl, ShiftSrc, ShiftAmt;
  logic [1:0] IorD, ALUSrcA, ALUSrcB, RegDst, LSCtrl, SSCtrl, ExcptCtrl;
  logic [2:0] ShiftCtrl, PCSrc, ALUCtrl;
  logic [3:0] DataSrc;

  control_unit #(.MD_CYCLES(MD)) dut (
    .clk(clk), .reset(reset), .opCode(opCode), .funct(funct),
    .eqf(eqf), .gtf(gtf), .ov(ov), .div0(div0),
    .MemCtrl(MemCtrl), .PCCtrl(PCCtrl), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ALUOutCtrl(ALUOutCtrl), .EPCCtrl(EPCCtrl), .HILOWrite(HILOWrite), .start(start),
    .MDCtrl(MDCtrl), .SECtrl(SECtrl), .ShiftSrc(ShiftSrc), .ShiftAmt(ShiftAmt),
    .IorD(IorD), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegDst(RegDst),
    .LSCtrl(LSCtrl), .SSCtrl(SSCtrl), .ExcptCtrl(ExcptCtrl), .ShiftCtrl(ShiftCtrl),
    .PCSrc(PCSrc), .ALUCtrl(ALUCtrl), .DataSrc(DataSrc)
  );

  always #5 clk = ~clk;

  ctl_t act;
  assign act = {MemCtrl, PCCtrl, IRWrite, RegWrite, ALUOutCtrl, EPCCtrl, HILOWrite, start,
                MDCtrl, SECtrl, ShiftSrc, ShiftAmt, IorD, ALUSrcA, ALUSrcB, RegDst,
                LSCtrl, SSCtrl, ExcptCtrl, ShiftCtrl, PCSrc, ALUCtrl, DataSrc};

  int total = 0;
  int bad = 0;
  int cyc = 0;
  ctl_t  exp_q[$];
  string nm_q[$];
  int    pin_got[$], pin_want[$];
  string pin_nm[$];

  ctl_t  seq[$];
  string tag[$];
  logic [5:0] nx_op = '0, nx_fn = '0;
  logic nx_eq = 0, nx_ov = 0, nx_d0 = 0, nx_rst = 1;

  // Single compare process: model pins first, then this cycle's expected control word.
  initial begin
    ctl_t e;
    string n;
    forever begin
      @(negedge clk);
      while (pin_got.size() > 0) begin
        total++;
        if (pin_got[0] != pin_want[0]) begin
          bad++;
          $display("FAIL pin %s: got %0d want %0d", pin_nm[0], pin_got[0], pin_want[0]);
        end
        void'(pin_got.pop_front());
        void'(pin_want.pop_front());
        void'(pin_nm.pop_front());
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        total++;
        if (act !== e) begin
          bad++;
          $display("FAIL %s cyc=%0d: got %h want %h", n, cyc, act, e);
        end
      end
    end
  end

  task automatic pin(input string n, input int got, input int want);
    pin_nm.push_back(n);
    pin_got.push_back(got);
    pin_want.push_back(want);
  endtask

  task automatic push(input ctl_t c, input string t);
    seq.push_back(c);
    tag.push_back(t);
  endtask

  task automatic step(input ctl_t c, input string t);
    @(posedge clk);
    #1;
    cyc++;
    reset = nx_rst; opCode = nx_op; funct = nx_fn;
    eqf = nx_eq; ov = nx_ov; div0 = nx_d0;
    exp_q.push_back(c);
    nm_q.push_back(t);
  endtask

  task automatic exc_seq(input logic [1:0] cause);
    ctl_t c;
    c = '0; c.asb = 2'd1; c.aluc = 3'b010; c.epcc = 1; push(c, "exc_epc");
    c = '0; c.iord = 2'd3; c.exc = cause;              push(c, "exc_vec_rd");
    c = '0;                                             push(c, "exc_wait");
    c = '0; c.ls = 2'd2; c.pcs = 3'd3; c.pcc = 1;       push(c, "exc_pc");
  endtask

  // Per-cycle control words for one instruction, from fetch to its last cycle.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic eq,
                       input logic ovf, input logic d0);
    ctl_t c;
    logic md;
    seq.delete(); tag.delete();
    nx_op = op; nx_fn = fn; nx_eq = eq; nx_ov = ovf; nx_d0 = d0;
    c = '0; push(c, "fetch0"); push(c, "fetch1");
    c.irw = 1; c.asb = 2'd1; c.aluc = 3'b001; c.pcc = 1; push(c, "fetch2");
    c = '0; c.asb = 2'd3; c.aluc = 3'b001; c.aoc = 1; push(c, "decode");
    c = '0;
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
      c.asa = 2'd1; c.aoc = 1;
      c.aluc = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : 3'b011;
      push(c, "alu_r");
      if (ovf && fn != 6'h24) exc_seq(2'd1);
      else begin c = '0; c.rw = 1; c.rdst = 2'd1; push(c, "wb_r"); end
    end else if (op == 6'h08 || op == 6'h0A) begin
      c.asa = 2'd1; c.asb = 2'd2; c.aoc = 1;
      c.aluc = (op == 6'h08) ? 3'b001 : 3'b111;
      push(c, "alu_i");
      if (ovf && op == 6'h08) exc_seq(2'd1);
      else begin c = '0; c.rw = 1; push(c, "wb_i"); end
    end else if (op == 6'h00 && (fn == 6'h00 || fn == 6'h02)) begin
      c.shs = 1; c.sha = 1; c.shc = (fn == 6'h00) ? 3'd2 : 3'd3; push(c, "shift");
      c = '0; c.rw = 1; c.rdst = 2'd1; c.ds = 4'd8; push(c, "wb_shift");
    end else if (op == 6'h0F) begin
      c.rw = 1; c.ds = 4'd6; push(c, "lui");
    end else if (op == 6'h00 && (fn == 6'h10 || fn == 6'h12)) begin
      c.rw = 1; c.rdst = 2'd1; c.ds = (fn == 6'h10) ? 4'd2 : 4'd3; push(c, "mfhilo");
    end else if (op == 6'h00 && fn == 6'h08) begin
      c.asa = 2'd1; c.aluc = 3'b001; c.pcc = 1; push(c, "jr");
    end else if (op == 6'h04 || op == 6'h05) begin
      c.asa = 2'd1; c.aluc = 3'b111; c.pcs = 3'd1;
      c.pcc = (op == 6'h04) ? eq : !eq;
      push(c, "branch");
    end else if (op == 6'h02 || op == 6'h03) begin
      c.pcs = 3'd2; c.pcc = 1;
      if (op == 6'h03) begin c.rw = 1; c.rdst = 2'd3; c.ds = 4'd4; end
      push(c, "jump");
    end else if (op == 6'h23 || op == 6'h2B) begin
      c.asa = 2'd1; c.asb = 2'd2; c.aluc = 3'b001; c.aoc = 1; push(c, "mem_addr");
      c = '0; c.iord = 2'd2; push(c, "mem_rd");
      if (op == 6'h23) begin
        c = '0; push(c, "lw_wait");
        c = '0; c.rw = 1; c.ds = 4'd1; push(c, "lw_wb");
      end else begin
        c.memc = 1; push(c, "sw_wr");
      end
    end else if (op == 6'h00 && (fn == 6'h18 || fn == 6'h1A)) begin
      md = (fn == 6'h1A);
      c.mdc = md; c.start = 1; push(c, "md_start");
      c.start = 0;
      for (int i = 0; i < MD; i++) push(c, "md_wait");
      if (md && d0) exc_seq(2'd2);
      else begin c.hilo = 1; push(c, "md_write"); end
    end else begin
      exc_seq(2'd0);
    end
  endtask

  task automatic play();
    for (int i = 0; i < seq.size(); i++) step(seq[i], tag[i]);
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic eq,
                     input logic ovf, input logic d0);
    build(op, fn, eq, ovf, d0);
    play();
  endtask

  initial begin
    int s, h, n;
    ctl_t z;
    z = '0;
    nx_rst = 1;
    repeat (3) step(z, "reset");
    nx_rst = 0;
    step(z, "reset_release");

    // add: write-back on cycle 6 counting FETCH0 as cycle 1
    build(6'h00, 6'h20, 0, 0, 0);
    pin("add_len", seq.size(), 6);
    pin("add_wb", int'({seq[5].rw, seq[5].rdst, seq[5].ds}), 7'b1_01_0000);
    play();
    run(6'h00, 6'h20, 0, 1, 0);
    run(6'h00, 6'h22, 0, 0, 0);
    run(6'h00, 6'h22, 0, 1, 0);
    run(6'h00, 6'h24, 0, 1, 0);
    run(6'h08, 6'h15, 0, 0, 0);
    run(6'h08, 6'h00, 0, 1, 0);
    run(6'h0A, 6'h3F, 0, 0, 0);
    run(6'h00, 6'h00, 0, 0, 0);
    run(6'h00, 6'h02, 0, 0, 0);
    run(6'h0F, 6'h00, 0, 0, 0);
    run(6'h00, 6'h10, 0, 0, 0);
    run(6'h00, 6'h12, 0, 0, 0);
    run(6'h00, 6'h08, 0, 0, 0);

    build(6'h04, 6'h00, 1, 0, 0);
    pin("beq_taken_c5", int'({seq[4].pcc, seq[4].pcs}), 4'b1_001);
    play();
    build(6'h04, 6'h00, 0, 0, 0);
    pin("beq_not_taken_c5", int'(seq[4].pcc), 0);
    play();
    run(6'h05, 6'h00, 0, 0, 0);
    run(6'h05, 6'h00, 1, 0, 0);
    run(6'h02, 6'h00, 0, 0, 0);
    run(6'h03, 6'h00, 0, 0, 0);
    run(6'h23, 6'h00, 0, 0, 0);
    run(6'h2B, 6'h00, 0, 0, 0);

    build(6'h00, 6'h18, 0, 0, 0);
    s = -1; h = -1; n = 0;
    for (int i = 0; i < seq.size(); i++) begin
      if (seq[i].start) begin n++; if (s < 0) s = i; end
      if (seq[i].hilo && h < 0) h = i;
    end
    pin("mult_start_count", n, 1);
    pin("mult_start_to_hilo", h - s, 34);
    play();
    run(6'h00, 6'h1A, 0, 0, 0);
    run(6'h00, 6'h1A, 0, 0, 1);

    build(6'h3F, 6'h00, 0, 0, 0);
    n = 0;
    for (int i = 0; i < seq.size(); i++) if (seq[i].rw) n++;
    pin("bad_op_epc", int'(seq[4].epcc), 1);
    pin("bad_op_vec", int'({seq[5].iord, seq[5].exc}), 4'b11_00);
    pin("bad_op_pc", int'({seq[7].pcs, seq[7].pcc}), 4'b011_1);
    pin("bad_op_no_regwrite", n, 0);
    play();
    run(6'h00, 6'h3F, 0, 0, 0);

    // mult aborted by reset ten cycles after its start pulse
    build(6'h00, 6'h18, 0, 0, 0);
    for (int i = 0; i < 14; i++) step(seq[i], tag[i]);
    nx_rst = 1;
    step(seq[14], "md_wait_pre_reset");
    nx_rst = 0;
    step(z, "reset_mid_mult");
    run(6'h00, 6'h18, 0, 0, 0);
    run(6'h00, 6'h20, 0, 0, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
